// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input vectors through N_OUT truth tables, one per clock, with per-output ones counters.
// Optional result signature register built only when TT_SIGNATURE_EN is defined.
module tt_lane #(
  parameter int N_IN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [(1<<N_IN)-1:0] lut_in,
  input  logic [N_IN-1:0]      vec_nxt,
  output logic                 res_nxt,
  output logic [N_IN:0]        cnt
);
  localparam int NV = 1 << N_IN;

  logic [NV-1:0] lut_q;

  // On accept the table is not yet captured, so look up the live input.
  assign res_nxt = load ? lut_in[vec_nxt] : lut_q[vec_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      lut_q <= lut_in;
      cnt   <= {{N_IN{1'b0}}, res_nxt};
    end else if (step) begin
      cnt   <= cnt + {{N_IN{1'b0}}, res_nxt};
    end
  end
endmodule

module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_OUT*(1<<N_IN)-1:0]    lut,
  input  logic                          find_en,
  input  logic [N_OUT-1:0]              target,
  output logic                          busy,
  output logic                          vec_valid,
  output logic [N_IN-1:0]               vec_out,
  output logic [N_OUT-1:0]              res_out,
  output logic [N_OUT*(N_IN+1)-1:0]     ones_cnt,
  output logic                          done,
  output logic                          found,
  output logic [7:0]                    sig
);
  localparam int NV = 1 << N_IN;
  localparam int CW = N_IN + 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic             find_en;
    logic [N_OUT-1:0] target;
  } cfg_t;

  state_t                       state_q, state_d;
  cfg_t                         cfg_q;
  logic                         accept, step, finish, match, last;
  logic [N_IN-1:0]              vec_nxt;
  logic [N_OUT-1:0]             res_nxt;
  logic [N_OUT-1:0][CW-1:0]     cnt_w;

  assign match   = cfg_q.find_en && (res_out == cfg_q.target);
  assign last    = (vec_out == {N_IN{1'b1}});
  assign vec_nxt = accept ? '0 : vec_out + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (match || last) begin
        finish  = 1'b1;
        state_d = IDLE;
      end else begin
        step    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  genvar j;
  generate
    for (j = 0; j < N_OUT; j++) begin : g_lane
      tt_lane #(.N_IN(N_IN)) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .step    (step),
        .lut_in  (lut[j*NV +: NV]),
        .vec_nxt (vec_nxt),
        .res_nxt (res_nxt[j]),
        .cnt     (cnt_w[j])
      );
    end
  endgenerate

  assign ones_cnt = cnt_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      vec_valid <= 1'b0;
      vec_out   <= '0;
      res_out   <= '0;
      done      <= 1'b0;
      found     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        cfg_q     <= '{find_en: find_en, target: target};
        vec_valid <= 1'b1;
        found     <= 1'b0;
      end else if (finish) begin
        vec_valid <= 1'b0;
        found     <= match;
      end
      if (accept || step) begin
        vec_out <= vec_nxt;
        res_out <= res_nxt;
      end
    end
  end

  assign busy = vec_valid;

`ifdef TT_SIGNATURE_EN
  logic [7:0] sig_q;

  // Cleared on accept, so the first update reduces to loading f(0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sig_q <= '0;
    else if (accept) sig_q <= 8'(res_nxt);
    else if (step)   sig_q <= {sig_q[6:0], sig_q[7]} ^ 8'(res_nxt);
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper, N_IN=3, N_OUT=2, lut=16'h96E8 (majority / 3-input XOR).
module tb_truth_table_sweeper;
  localparam logic [15:0] LUT = 16'h96E8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] lut = '0;
  logic        find_en = 1'b0;
  logic [1:0]  target = '0;
  logic        busy, vec_valid, done, found;
  logic [2:0]  vec_out;
  logic [1:0]  res_out;
  logic [7:0]  ones_cnt;
  logic [7:0]  sig;

  int checks = 0;
  int errors = 0;

  // Hand-derived per-vector expectations: results, cumulative {field1,field0}, signature.
  logic [1:0] exp_res [8] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd3};
  logic [7:0] exp_cnt [8] = '{8'h00, 8'h10, 8'h20, 8'h21, 8'h31, 8'h32, 8'h33, 8'h44};
`ifdef TT_SIGNATURE_EN
  logic [7:0] exp_sig [8] = '{8'h00, 8'h02, 8'h06, 8'h0D, 8'h18, 8'h31, 8'h63, 8'hC5};
`else
  logic [7:0] exp_sig [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

  truth_table_sweeper #(.N_IN(3), .N_OUT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lut       (lut),
    .find_en   (find_en),
    .target    (target),
    .busy      (busy),
    .vec_valid (vec_valid),
    .vec_out   (vec_out),
    .res_out   (res_out),
    .ones_cnt  (ones_cnt),
    .done      (done),
    .found     (found),
    .sig       (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".vld"},   32'(vec_valid), 0);
    chk({tag, ".vec"},   32'(vec_out), 0);
    chk({tag, ".res"},   32'(res_out), 0);
    chk({tag, ".cnt"},   32'(ones_cnt), 0);
    chk({tag, ".done"},  32'(done), 0);
    chk({tag, ".found"}, 32'(found), 0);
    chk({tag, ".sig"},   32'(sig), 0);
  endtask

  // Start a sweep and check every presented vector up to stop_v, then the done cycle.
  task automatic sweep(input string tag, input logic f_en, input logic [1:0] tgt,
                       input int stop_v, input logic exp_found, input logic disturb);
    @(negedge clk);
    lut = LUT; find_en = f_en; target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int v = 0; v <= stop_v; v++) begin
      chk($sformatf("%s.v%0d.vld", tag, v),  32'(vec_valid), 1);
      chk($sformatf("%s.v%0d.busy", tag, v), 32'(busy), 1);
      chk($sformatf("%s.v%0d.vec", tag, v),  32'(vec_out), 32'(v));
      chk($sformatf("%s.v%0d.res", tag, v),  32'(res_out), 32'(exp_res[v]));
      chk($sformatf("%s.v%0d.cnt", tag, v),  32'(ones_cnt), 32'(exp_cnt[v]));
      chk($sformatf("%s.v%0d.sig", tag, v),  32'(sig), 32'(exp_sig[v]));
      chk($sformatf("%s.v%0d.done", tag, v), 32'(done), 0);
      if (disturb && (v == 2 || v == 4)) begin
        start = 1'b1; lut = 16'h1234; target = ~tgt; find_en = ~f_en;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; lut = LUT; find_en = 1'b0; target = '0;
    chk({tag, ".done"},  32'(done), 1);
    chk({tag, ".vld"},   32'(vec_valid), 0);
    chk({tag, ".busy"},  32'(busy), 0);
    chk({tag, ".found"}, 32'(found), 32'(exp_found));
    chk({tag, ".vec"},   32'(vec_out), 32'(stop_v));
    chk({tag, ".res"},   32'(res_out), 32'(exp_res[stop_v]));
    chk({tag, ".cnt"},   32'(ones_cnt), 32'(exp_cnt[stop_v]));
    chk({tag, ".sig"},   32'(sig), 32'(exp_sig[stop_v]));
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".found_hold"}, 32'(found), 32'(exp_found));
    chk({tag, ".sig_hold"},   32'(sig), 32'(exp_sig[stop_v]));
    chk({tag, ".idle_busy"},  32'(busy), 0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sweep("full",  1'b0, 2'b00, 7, 1'b0, 1'b0);
    sweep("find01", 1'b1, 2'b01, 3, 1'b1, 1'b0);
    sweep("find11", 1'b1, 2'b11, 7, 1'b1, 1'b0);
    sweep("disturb", 1'b0, 2'b00, 7, 1'b0, 1'b1);

    // Reset while vector 4 is presented.
    @(negedge clk);
    lut = LUT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst.pre_vec", 32'(vec_out), 4);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(negedge clk);
    chk_zero("rst_held");
    rst_n = 1'b1;

    sweep("after_rst", 1'b0, 2'b00, 7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequential successor to the team's fixed 3-input boolean lab blocks.
- Sweeps every one of the 2^N_IN input combinations, one per clock, through N_OUT programmable boolean functions supplied as a truth-table vector.
- Streams each vector and its results, counts ones per output, and optionally stops at the first vector whose result equals a target.
- Sits between a lab stimulus/controller and the display/checker logic.

## Interface
- N_IN, 3: number of function inputs; 1..8.
- N_OUT, 2: number of functions/outputs; 1..8.
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- lut  in  N_OUT*2^N_IN  truth tables; output j at vector v = lut[j*2^N_IN + v]; captured on start
- find_en  in  1  stop at first match; captured on start
- target  in  N_OUT  match value for find mode; captured on start
- busy  out  1  high in RUN
- vec_valid  out  1  vec_out/res_out hold a presented vector this cycle
- vec_out  out  N_IN  current input combination
- res_out  out  N_OUT  function results for vec_out; bit j = output j
- ones_cnt  out  N_OUT*(N_IN+1)  per-output count of ones over presented vectors; field j at [j*(N_IN+1) +: N_IN+1]
- done  out  1  one-cycle pulse at end of sweep
- found  out  1  last sweep stopped on a match; held until next start
- sig  out  8  result signature (see Configuration)

## Operation
- States: IDLE, RUN.
  - IDLE -> RUN on start=1.
  - RUN -> IDLE after vector 2^N_IN-1 is presented.
  - RUN -> IDLE after a presented vector matches, when find_en is captured high.
- On the accepting edge:
  - lut, find_en and target are captured; later changes to these inputs have no effect until the next start.
  - Vector 0 is presented: vec_out=0, res_out=f(0), vec_valid=1.
  - ones_cnt is loaded with the ones of f(0); found=0; sig is initialised.
- Each subsequent RUN edge:
  - vec_out increments by 1 and res_out = f(vec_out).
  - Each ones_cnt field adds its res_out bit.
  - sig updates.
- Match: res_out == target while vec_valid and find_en are high. On the next edge:
  - found=1, done=1, vec_valid=0.
  - vec_out, res_out and ones_cnt hold their values from the matching vector.
- Full sweep without a match:
  - After vector 2^N_IN-1, the next edge sets done=1, vec_valid=0, found=0.
  - vec_out holds 2^N_IN-1.
- Counters are N_IN+1 bits wide (maximum value 2^N_IN), so they never wrap. vec_out never wraps.
- start while busy is ignored.
- start held high through done restarts the sweep on the edge after done, since the block is back in IDLE.
- Reset, including mid-sweep: every output is 0 and the state is IDLE.

## Timing
- Reset values: busy=0, vec_valid=0, vec_out=0, res_out=0, ones_cnt=0, done=0, found=0, sig=0.
- Start sampled at edge E: vector k is presented in the cycle after edge E+k.
- busy is high for the same cycles as vec_valid.
- Full sweep: done pulses in the cycle after edge E+2^N_IN, giving a total of 2^N_IN+1 cycles from start to done.
- Find mode with a match at vector m: done pulses in the cycle after edge E+m+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- TT_SIGNATURE_EN defined:
  - sig is cleared to 0 on accept, then updated with res_out zero-extended to 8 bits: sig <= {sig[6:0],sig[7]} ^ res_out.
  - The update is applied on the accepting edge and on every RUN edge that presents a vector.
  - sig holds after done.
- TT_SIGNATURE_EN not defined: sig is tied to 0 and no signature register is built.

## Test plan
All scenarios use N_IN=3, N_OUT=2 and lut=16'h96E8 (output0 = majority, output1 = 3-input XOR).
- Full sweep, find_en=0, TT_SIGNATURE_EN defined:
  - res_out sequence for vectors 0..7 is 0,2,2,1,2,1,1,3.
  - done pulses 9 cycles after start; ones_cnt = {4'd4... field1=4, field0=4}; found=0; sig=8'hC5.
- Find mode, target=2'b01: stops at vector 3 with ones_cnt field0=1, field1=2; found=1; done 5 cycles after start.
- Find mode, target=2'b11: matches at vector 7; found=1; done 9 cycles after start.
- Start pulsed at cycles 2 and 4 of a sweep, and lut changed mid-sweep: no restart and results unchanged; sweep completes with the original values.
- rst_n asserted during vector 4: all outputs go to 0 immediately. A new start afterwards gives the full-sweep results above.
- Build without TT_SIGNATURE_EN: sig=0 throughout the full sweep; all other outputs are identical to the first scenario.
